// File: rtl/pic_pkg.sv
// Shared PIC16F1826 core constants: register addresses, INTCON/OPTION_REG bit
// positions and the register-window select type used by peripheral windows.
package pic_pkg;

  localparam logic [6:0] ADDR_INTCON = 7'h0B;
  localparam logic [6:0] ADDR_IOCBP  = 7'h14;
  localparam logic [6:0] ADDR_IOCBN  = 7'h15;
  localparam logic [6:0] ADDR_IOCBF  = 7'h16;

  localparam int unsigned INTCON_GIE    = 7;
  localparam int unsigned INTCON_PEIE   = 6;
  localparam int unsigned INTCON_TMR0IE = 5;
  localparam int unsigned INTCON_INTE   = 4;
  localparam int unsigned INTCON_IOCIE  = 3;
  localparam int unsigned INTCON_TMR0IF = 2;
  localparam int unsigned INTCON_INTF   = 1;
  localparam int unsigned INTCON_IOCIF  = 0;

  localparam int unsigned OPTION_INTEDG = 6;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_IOCBP,
    REG_IOCBN,
    REG_IOCBF
  } reg_sel_e;

endpackage

// File: rtl/pin_sync.sv
// Two-flop synchronizer per pin plus a previous-value register; reports
// per-pin rising and falling edges of the synchronized levels.
module pin_sync #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;

  always_comb begin
    meta_d = pin_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/portb_int_unit.sv
// PORTB external-interrupt (RB0/INT) and interrupt-on-change source: flags,
// event pulses to the core and the IOCBP/IOCBN/IOCBF register window.
module portb_int_unit #(
  parameter int unsigned WIDTH      = 8,
  parameter logic [6:0]  ADDR_IOCBP = pic_pkg::ADDR_IOCBP,
  parameter logic [6:0]  ADDR_IOCBN = pic_pkg::ADDR_IOCBN,
  parameter logic [6:0]  ADDR_IOCBF = pic_pkg::ADDR_IOCBF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  input  logic             intedg,
  input  logic             sel,
  input  logic             we,
  input  logic [6:0]       addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  input  logic             intf_clr,
  output logic             intf,
  output logic             iocif,
  output logic             int_evt,
  output logic             ioc_evt
);

  import pic_pkg::*;

  logic [WIDTH-1:0] rise, fall;

  pin_sync #(.WIDTH(WIDTH)) u_pin_sync (
    .clk    (clk),
    .rst    (rst),
    .pin_in (pin_in),
    .rise   (rise),
    .fall   (fall)
  );

  logic [WIDTH-1:0] iocbp_q, iocbp_d;
  logic [WIDTH-1:0] iocbn_q, iocbn_d;
  logic [WIDTH-1:0] iocbf_q, iocbf_d;
  logic             intf_q, intf_d;
  logic             intf_prev_q, intf_prev_d;
  logic             iocif_prev_q, iocif_prev_d;
  logic             int_evt_q, int_evt_d;
  logic             ioc_evt_q, ioc_evt_d;

  reg_sel_e         reg_sel;
  logic [WIDTH-1:0] wdata_w;
  logic [WIDTH-1:0] ioc_set;
  logic             int_set;
  logic             wr_en;

  always_comb begin
    reg_sel = REG_NONE;
    if (sel) begin
      if (addr == ADDR_IOCBP)      reg_sel = REG_IOCBP;
      else if (addr == ADDR_IOCBN) reg_sel = REG_IOCBN;
      else if (addr == ADDR_IOCBF) reg_sel = REG_IOCBF;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_IOCBP: rdata = 8'(iocbp_q);
      REG_IOCBN: rdata = 8'(iocbn_q);
      REG_IOCBF: rdata = 8'(iocbf_q);
      default:   rdata = '0;
    endcase
  end

  always_comb begin
    wdata_w = WIDTH'(wdata);
    wr_en   = we && (reg_sel != REG_NONE);
    int_set = intedg ? rise[0] : fall[0];
    // Edges are qualified by the enables currently held, so a same-cycle
    // enable write only affects later edges.
    ioc_set = (iocbp_q & rise) | (iocbn_q & fall);

    iocbp_d = iocbp_q;
    iocbn_d = iocbn_q;
    if (wr_en && reg_sel == REG_IOCBP) iocbp_d = wdata_w;
    if (wr_en && reg_sel == REG_IOCBN) iocbn_d = wdata_w;

    // Hardware set is OR-ed in last so it always beats a software clear.
    iocbf_d = ((wr_en && reg_sel == REG_IOCBF) ? wdata_w : iocbf_q) | ioc_set;

    intf_d = int_set | (intf_q & ~intf_clr);

    intf_prev_d  = intf_q;
    iocif_prev_d = |iocbf_q;
    int_evt_d    = intf_q & ~intf_prev_q;
    ioc_evt_d    = (|iocbf_q) & ~iocif_prev_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iocbp_q      <= '0;
      iocbn_q      <= '0;
      iocbf_q      <= '0;
      intf_q       <= 1'b0;
      intf_prev_q  <= 1'b0;
      iocif_prev_q <= 1'b0;
      int_evt_q    <= 1'b0;
      ioc_evt_q    <= 1'b0;
    end else begin
      iocbp_q      <= iocbp_d;
      iocbn_q      <= iocbn_d;
      iocbf_q      <= iocbf_d;
      intf_q       <= intf_d;
      intf_prev_q  <= intf_prev_d;
      iocif_prev_q <= iocif_prev_d;
      int_evt_q    <= int_evt_d;
      ioc_evt_q    <= ioc_evt_d;
    end
  end

  assign intf    = intf_q;
  assign iocif   = |iocbf_q;
  assign int_evt = int_evt_q;
  assign ioc_evt = ioc_evt_q;

endmodule

// File: tb/tb_portb_int_unit.sv
// Directed bench for portb_int_unit: a sample-history model checked every
// cycle plus hand-computed expectations for each scenario.
module tb_portb_int_unit;

  localparam logic [6:0] A_IOCBP = 7'h14;
  localparam logic [6:0] A_IOCBN = 7'h15;
  localparam logic [6:0] A_IOCBF = 7'h16;

  logic       clk;
  logic       rst;
  logic [7:0] pin_in;
  logic       intedg;
  logic       sel;
  logic       we;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       intf_clr;
  logic       intf;
  logic       iocif;
  logic       int_evt;
  logic       ioc_evt;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned n_int = 0;
  int unsigned n_ioc = 0;
  int unsigned n0, n1;

  portb_int_unit #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .pin_in   (pin_in),
    .intedg   (intedg),
    .sel      (sel),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .intf_clr (intf_clr),
    .intf     (intf),
    .iocif    (iocif),
    .int_evt  (int_evt),
    .ioc_evt  (ioc_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: pins as sampled at each clock edge. The flag update at edge n sees
  // the sample pair from edges n-2 / n-3; pulses lag the flag by one more edge.
  logic [7:0] m_smp [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] m_iocbp = '0, m_iocbn = '0, m_iocbf = '0;
  logic [7:0] m_rise, m_fall, m_set;
  logic       m_intf = 1'b0, m_intf_old = 1'b0, m_iocif_old = 1'b0;
  logic       m_int_evt = 1'b0, m_ioc_evt = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_smp = '{8'h00, 8'h00, 8'h00};
      m_iocbp = '0; m_iocbn = '0; m_iocbf = '0;
      m_intf = 1'b0; m_intf_old = 1'b0; m_iocif_old = 1'b0;
      m_int_evt = 1'b0; m_ioc_evt = 1'b0;
    end else begin
      m_rise = m_smp[1] & ~m_smp[2];
      m_fall = ~m_smp[1] & m_smp[2];
      m_int_evt = m_intf && !m_intf_old;
      m_ioc_evt = (m_iocbf != 0) && !m_iocif_old;
      m_intf_old  = m_intf;
      m_iocif_old = (m_iocbf != 0);
      if (intedg ? m_rise[0] : m_fall[0]) m_intf = 1'b1;
      else if (intf_clr)                   m_intf = 1'b0;
      m_set = (m_iocbp & m_rise) | (m_iocbn & m_fall);
      if (sel && we && addr == A_IOCBF) m_iocbf = wdata | m_set;
      else                              m_iocbf = m_iocbf | m_set;
      if (sel && we && addr == A_IOCBP) m_iocbp = wdata;
      if (sel && we && addr == A_IOCBN) m_iocbn = wdata;
      m_smp[2] = m_smp[1];
      m_smp[1] = m_smp[0];
      m_smp[0] = pin_in;
    end
  end

  function automatic logic [7:0] m_rd();
    if (!sel) return 8'h00;
    case (addr)
      A_IOCBP: return m_iocbp;
      A_IOCBN: return m_iocbn;
      A_IOCBF: return m_iocbf;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    check("cyc_intf",    8'(intf),    8'(m_intf));
    check("cyc_iocif",   8'(iocif),   8'(m_iocbf != 0));
    check("cyc_int_evt", 8'(int_evt), 8'(m_int_evt));
    check("cyc_ioc_evt", 8'(ioc_evt), 8'(m_ioc_evt));
    check("cyc_rdata",   rdata,       m_rd());
    if (int_evt === 1'b1) n_int++;
    if (ioc_evt === 1'b1) n_ioc++;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    cyc();
    we = 1'b0; sel = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, input logic [7:0] exp, input string nm);
    sel = 1'b1; addr = a;
    #1;
    check(nm, rdata, exp);
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b0; pin_in = 8'hFF; intedg = 1'b0; sel = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; intf_clr = 1'b0;

    // Pins high through reset with no enables and falling-edge INT.
    repeat (3) cyc();
    check("rst_intf", 8'(intf), 8'h00);
    rd(A_IOCBF, 8'h00, "rst_iocbf");
    rst = 1'b1;
    repeat (6) cyc();
    rd(A_IOCBF, 8'h00, "hold_iocbf");
    check("hold_iocif", 8'(iocif), 8'h00);
    check("hold_intf", 8'(intf), 8'h00);
    check("hold_ioc_evt_cnt", 8'(n_ioc), 8'h00);

    // RB0 falling with INTEDG=0 sets INTF; clear it.
    pin_in = 8'h00;
    repeat (6) cyc();
    check("fall_intf", 8'(intf), 8'h01);
    intf_clr = 1'b1; cyc(); intf_clr = 1'b0; cyc();
    check("clr_intf", 8'(intf), 8'h00);

    // Rising-edge INT latency.
    intedg = 1'b1;
    repeat (2) cyc();
    n0 = n_int;
    pin_in = 8'h01;
    cyc(); check("int_e1", 8'(intf), 8'h00);
    cyc(); check("int_e2", 8'(intf), 8'h00);
    cyc(); check("int_e3", 8'(intf), 8'h01);
    check("int_evt_e3", 8'(int_evt), 8'h00);
    cyc(); check("int_evt_e4", 8'(int_evt), 8'h01);
    cyc(); check("int_evt_e5", 8'(int_evt), 8'h00);
    check("int_evt_cnt", 8'(n_int - n0), 8'h01);
    pin_in = 8'h00; repeat (3) cyc();
    pin_in = 8'h01; repeat (6) cyc();
    check("int_no_retrig", 8'(n_int - n0), 8'h01);
    intf_clr = 1'b1; cyc(); intf_clr = 1'b0;
    check("int_clr", 8'(intf), 8'h00);

    // IOC on both polarities.
    wr(A_IOCBP, 8'h10);
    wr(A_IOCBN, 8'h20);
    pin_in = 8'h21; repeat (5) cyc();
    rd(A_IOCBF, 8'h00, "ioc_rb5_rise_ignored");
    n1 = n_ioc;
    pin_in = 8'h11; repeat (6) cyc();
    rd(A_IOCBF, 8'h30, "ioc_both");
    check("ioc_iocif", 8'(iocif), 8'h01);
    check("ioc_evt_cnt", 8'(n_ioc - n1), 8'h01);
    pin_in = 8'h21; repeat (6) cyc();
    rd(A_IOCBF, 8'h30, "ioc_wrong_pol");
    check("ioc_evt_cnt2", 8'(n_ioc - n1), 8'h01);

    // Software clear racing a hardware set on RB6.
    wr(A_IOCBF, 8'h10);
    rd(A_IOCBF, 8'h10, "race_pre");
    wr(A_IOCBP, 8'h50);
    pin_in = 8'h61;
    cyc(); cyc();
    sel = 1'b1; we = 1'b1; addr = A_IOCBF; wdata = 8'h00;
    cyc();
    we = 1'b0; sel = 1'b0;
    rd(A_IOCBF, 8'h40, "race_set_wins");

    // Sub-period glitch on RB7 lies between clock edges; 2-cycle pulse is seen.
    wr(A_IOCBP, 8'h80);
    wr(A_IOCBF, 8'h00);
    rd(A_IOCBF, 8'h00, "glitch_pre");
    #1 pin_in = 8'hE1;
    #3 pin_in = 8'h61;
    repeat (5) cyc();
    rd(A_IOCBF, 8'h00, "glitch_reject");
    pin_in = 8'hE1; cyc(); cyc();
    pin_in = 8'h61; repeat (5) cyc();
    rd(A_IOCBF, 8'h80, "pulse_2cyc");

    // Register window decode.
    wr(A_IOCBP, 8'hA5);
    rd(A_IOCBP, 8'hA5, "win_iocbp");
    sel = 1'b0; addr = A_IOCBP; #1;
    check("win_sel0", rdata, 8'h00);
    rd(7'h17, 8'h00, "win_unmapped");

    // Asynchronous reset in the middle of a write.
    sel = 1'b1; we = 1'b1; addr = A_IOCBN; wdata = 8'hFF;
    #3 rst = 1'b0;
    #1 check("arst_iocbn", rdata, 8'h00);
    addr = A_IOCBP; #1 check("arst_iocbp", rdata, 8'h00);
    addr = A_IOCBF; #1 check("arst_iocbf", rdata, 8'h00);
    check("arst_intf", 8'(intf), 8'h00);
    cyc();
    we = 1'b0; sel = 1'b0;
    rst = 1'b1;
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
